// File: rtl/mult_share_sched.sv
// Round-robin scheduler sharing one shift-and-add multiplier datapath between two requesters.
// Optional build macro SKIP_ZERO_EN ends an operation early once no set multiplier bits remain.
module mult_share_sched #(
    parameter int WIDTH = 4
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [1:0]           REQ,
    input  logic [WIDTH-1:0]     A0,
    input  logic [WIDTH-1:0]     B0,
    input  logic [WIDTH-1:0]     A1,
    input  logic [WIDTH-1:0]     B1,
    input  logic [2*WIDTH-1:0]   ACC_Q,
    output logic                 OP_SEL,
    output logic [1:0]           SR_SEL,
    output logic                 ACC_LD,
    output logic                 ACC_CLR,
    output logic [1:0]           GNT,
    output logic [1:0]           DONE,
    output logic [2*WIDTH-1:0]   RESULT,
    output logic                 BUSY
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [1:0] SR_HOLD  = 2'd0;
    localparam logic [1:0] SR_LOAD  = 2'd1;
    localparam logic [1:0] SR_SHIFT = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_BIT     = 3'd2,
        S_CAPTURE = 3'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             last;
    logic [WIDTH-1:0] b_lat;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       eligible;
    logic             winner;
    logic             have_winner;
    logic [1:0]       grant_vec;

    // Multiplicands reach the datapath through the external operand mux driven by OP_SEL.
    logic unused_operands;
    assign unused_operands = ^{A0, A1};

    // A requester whose DONE is pulsing is not eligible, so a late-dropping REQ is not re-served.
    assign eligible    = REQ & ~DONE;
    assign have_winner = |eligible;
    assign winner      = (eligible == 2'b11) ? ~last : eligible[1];
    assign grant_vec   = OP_SEL ? 2'b10 : 2'b01;

`ifdef SKIP_ZERO_EN
    logic [WIDTH-1:0] b_remaining;
    logic             rest_zero;
    assign b_remaining = b_lat >> cnt;
    assign rest_zero   = (b_remaining[WIDTH-1:1] == '0);
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            last   <= 1'b1;
            OP_SEL <= 1'b0;
            b_lat  <= '0;
            cnt    <= '0;
            DONE   <= 2'b00;
            RESULT <= '0;
        end else begin
            DONE <= 2'b00;
            case (state)
                S_IDLE: begin
                    if (have_winner) begin
                        OP_SEL <= winner;
                        b_lat  <= winner ? B1 : B0;
                        last   <= winner;
                    end
                end
                S_LOAD: begin
                    cnt <= '0;
                end
                S_BIT: begin
                    cnt <= cnt + CNT_W'(1);
                end
                S_CAPTURE: begin
                    RESULT <= ACC_Q;
                    DONE   <= grant_vec;
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

    // One multiplier bit per BIT cycle, LSB first, while the datapath shifts the multiplicand.
    always_comb begin
        state_next = S_IDLE;
        SR_SEL     = SR_HOLD;
        ACC_LD     = 1'b0;
        ACC_CLR    = 1'b0;
        GNT        = 2'b00;
        BUSY       = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                state_next = have_winner ? S_LOAD : S_IDLE;
            end
            S_LOAD: begin
                SR_SEL     = SR_LOAD;
                ACC_CLR    = 1'b1;
                GNT        = grant_vec;
                state_next = S_BIT;
`ifdef SKIP_ZERO_EN
                if (b_lat == '0) begin
                    state_next = S_CAPTURE;
                end
`endif
            end
            S_BIT: begin
                SR_SEL     = SR_SHIFT;
                ACC_LD     = b_lat[cnt];
                GNT        = grant_vec;
                state_next = (cnt == CNT_LAST) ? S_CAPTURE : S_BIT;
`ifdef SKIP_ZERO_EN
                if (rest_zero) begin
                    state_next = S_CAPTURE;
                end
`endif
            end
            S_CAPTURE: begin
                GNT        = grant_vec;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mult_share_sched.sv
// Directed bench for mult_share_sched with a behavioural shift-and-add datapath model.
module tb_mult_share_sched;

    localparam int W = 4;

`ifdef SKIP_ZERO_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic           CLK = 1'b0;
    logic           RESET;
    logic [1:0]     REQ;
    logic [W-1:0]   A0, B0, A1, B1;
    logic [2*W-1:0] ACC_Q;
    logic           OP_SEL;
    logic [1:0]     SR_SEL;
    logic           ACC_LD, ACC_CLR;
    logic [1:0]     GNT, DONE;
    logic [2*W-1:0] RESULT;
    logic           BUSY;

    logic [2*W-1:0] sr, acc;

    int n_vec = 0;
    int n_miscmp = 0;

    typedef struct {
        logic [1:0]   req;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [1:0]   exp_done;
        logic [7:0]   exp_result;
        int           lat_full;
        int           lat_skip;
        int           exp_ld;
    } vec_t;

    vec_t tbl [8];
    logic [8:0] trace_full [7];
    logic [8:0] trace_skip [7];

    mult_share_sched #(.WIDTH(W)) dut (
        .CLK(CLK), .RESET(RESET), .REQ(REQ),
        .A0(A0), .B0(B0), .A1(A1), .B1(B1), .ACC_Q(ACC_Q),
        .OP_SEL(OP_SEL), .SR_SEL(SR_SEL), .ACC_LD(ACC_LD), .ACC_CLR(ACC_CLR),
        .GNT(GNT), .DONE(DONE), .RESULT(RESULT), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    // Shared datapath: shift register loaded from the steered multiplicand, accumulator adds it.
    always @(posedge CLK) begin
        if (RESET) begin
            sr  <= '0;
            acc <= '0;
        end else begin
            if (SR_SEL == 2'd1) sr <= {{W{1'b0}}, (OP_SEL ? A1 : A0)};
            else if (SR_SEL == 2'd2) sr <= sr << 1;
            if (ACC_CLR) acc <= '0;
            else if (ACC_LD) acc <= acc + sr;
        end
    end
    assign ACC_Q = acc;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_miscmp++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
    endtask

    task automatic check_reset_outputs(input string name);
        check_output({name, "_ctl"}, 32'({OP_SEL, SR_SEL, ACC_LD, ACC_CLR, GNT, DONE, BUSY}), 32'd0);
        check_output({name, "_result"}, 32'(RESULT), 32'd0);
    endtask

    task automatic wait_done(input string name, input int limit, output logic [1:0] d);
        bit got = 1'b0;
        d = 2'b00;
        for (int c = 0; c < limit && !got; c++) begin
            tick();
            if (DONE != 2'b00) begin
                got = 1'b1;
                d = DONE;
            end
        end
        if (!got) check_output({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic apply_stimulus(input vec_t v, input int idx);
        int cyc = 0;
        int ld = 0;
        bit got = 1'b0;
        logic [1:0] d = 2'b00;
        logic [7:0] r = '0;
        int exp_lat;
        tick();
        A0 = v.req[0] ? v.a : ~v.a;
        B0 = v.req[0] ? v.b : ~v.b;
        A1 = v.req[1] ? v.a : ~v.a;
        B1 = v.req[1] ? v.b : ~v.b;
        REQ = v.req;
        for (int c = 1; c <= 40 && !got; c++) begin
            tick();
            cyc = c;
            if ((GNT & REQ) != 2'b00) REQ = REQ & ~GNT;
            if (ACC_LD) ld++;
            if (DONE != 2'b00) begin
                got = 1'b1;
                d = DONE;
                r = RESULT;
            end
        end
        REQ = 2'b00;
        exp_lat = SKIP ? v.lat_skip : v.lat_full;
        if (!got) check_output($sformatf("vec%0d_timeout", idx), 32'd0, 32'd1);
        check_output($sformatf("vec%0d_done", idx), 32'(d), 32'(v.exp_done));
        check_output($sformatf("vec%0d_result", idx), 32'(r), 32'(v.exp_result));
        check_output($sformatf("vec%0d_latency", idx), 32'(cyc), 32'(exp_lat));
        check_output($sformatf("vec%0d_accld_count", idx), 32'(ld), 32'(v.exp_ld));
    endtask

    initial begin
        logic [1:0] d;
        logic [1:0] done_seen [4];
        logic [7:0] res_seen [4];
        logic [1:0] gnt_after [4];
        int ndone;
        int nafter;
        int stray;
        bit pend;

        tbl[0] = '{2'b01, 4'd3,  4'd5,  2'b01, 8'd15,  7, 6, 2};
        tbl[1] = '{2'b10, 4'd9,  4'd0,  2'b10, 8'd0,   7, 3, 0};
        tbl[2] = '{2'b10, 4'd7,  4'd2,  2'b10, 8'd14,  7, 5, 1};
        tbl[3] = '{2'b01, 4'd15, 4'd15, 2'b01, 8'd225, 7, 7, 4};
        tbl[4] = '{2'b10, 4'd15, 4'd8,  2'b10, 8'd120, 7, 7, 1};
        tbl[5] = '{2'b01, 4'd1,  4'd1,  2'b01, 8'd1,   7, 4, 1};
        tbl[6] = '{2'b01, 4'd0,  4'd9,  2'b01, 8'd0,   7, 7, 2};
        tbl[7] = '{2'b10, 4'd12, 4'd11, 2'b10, 8'd132, 7, 7, 3};

        // {SR_SEL, ACC_LD, ACC_CLR, GNT, DONE, BUSY} for cycles 1..7 of A0=3, B0=5
        trace_full = '{9'b01_0_1_01_00_1, 9'b10_1_0_01_00_1, 9'b10_0_0_01_00_1, 9'b10_1_0_01_00_1,
                       9'b10_0_0_01_00_1, 9'b00_0_0_01_00_1, 9'b00_0_0_00_01_0};
        trace_skip = '{9'b01_0_1_01_00_1, 9'b10_1_0_01_00_1, 9'b10_0_0_01_00_1, 9'b10_1_0_01_00_1,
                       9'b00_0_0_01_00_1, 9'b00_0_0_00_01_0, 9'b00_0_0_00_00_0};

        REQ = 2'b00; A0 = '0; B0 = '0; A1 = '0; B1 = '0;
        do_reset();
        check_reset_outputs("reset");

        A0 = 4'd3; B0 = 4'd5; A1 = 4'd10; B1 = 4'd6;
        REQ = 2'b01;
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (c == 2) REQ = 2'b00;
            check_output($sformatf("trace_c%0d", c), 32'({SR_SEL, ACC_LD, ACC_CLR, GNT, DONE, BUSY}),
                         32'(SKIP ? trace_skip[c-1] : trace_full[c-1]));
        end
        check_output("trace_result", 32'(RESULT), 32'd15);

        for (int i = 0; i < 8; i++) apply_stimulus(tbl[i], i);

        tick();
        A0 = 4'd3; B0 = 4'd5; REQ = 2'b01;
        wait_done("mask_first", 40, d);
        check_output("mask_first_done", 32'(d), 32'b01);
        tick();
        check_output("mask_no_regrant", 32'({BUSY, GNT}), 32'd0);
        tick();
        check_output("mask_later_regrant", 32'(GNT), 32'b01);
        REQ = 2'b00;
        wait_done("mask_second", 40, d);
        check_output("mask_second_result", 32'(RESULT), 32'd15);

        tick();
        A0 = 4'd3; B0 = 4'd5; A1 = 4'd6; B1 = 4'd6; REQ = 2'b01;
        tick();
        REQ = 2'b00;
        tick();
        tick();
        check_output("midreset_busy", 32'(BUSY), 32'd1);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        check_reset_outputs("midreset");
        stray = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (DONE != 2'b00) stray++;
        end
        check_output("midreset_no_done", 32'(stray), 32'd0);
        REQ = 2'b11;
        tick();
        check_output("midreset_pointer", 32'(GNT), 32'b01);
        REQ = 2'b10;
        wait_done("midreset_op0", 40, d);
        check_output("midreset_op0_done", 32'(d), 32'b01);
        check_output("midreset_op0_result", 32'(RESULT), 32'd15);
        wait_done("midreset_op1", 40, d);
        REQ = 2'b00;
        check_output("midreset_op1_done", 32'(d), 32'b10);
        check_output("midreset_op1_result", 32'(RESULT), 32'd36);

        do_reset();
        A0 = 4'd15; B0 = 4'd15; A1 = 4'd7; B1 = 4'd2; REQ = 2'b11;
        ndone = 0; nafter = 0; pend = 1'b0;
        for (int c = 0; c < 200 && nafter < 4; c++) begin
            tick();
            if (pend) begin
                gnt_after[nafter] = GNT;
                nafter++;
                pend = 1'b0;
            end
            if (DONE != 2'b00 && ndone < 4) begin
                done_seen[ndone] = DONE;
                res_seen[ndone] = RESULT;
                ndone++;
                pend = 1'b1;
            end
        end
        REQ = 2'b00;
        if (nafter < 4) begin
            check_output("rr_timeout", 32'(nafter), 32'd4);
        end else begin
            for (int k = 0; k < 4; k++) begin
                check_output($sformatf("rr%0d_done", k), 32'(done_seen[k]), (k % 2 == 0) ? 32'b01 : 32'b10);
                check_output($sformatf("rr%0d_result", k), 32'(res_seen[k]), (k % 2 == 0) ? 32'd225 : 32'd14);
                check_output($sformatf("rr%0d_next_gnt", k), 32'(gnt_after[k]), (k % 2 == 0) ? 32'b10 : 32'b01);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
